// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state
// encoding, port identifiers, default memory depth and a range helper.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        G_FETCH = 2'd1,
        G_LOAD  = 2'd2
    } state_t;

    typedef enum logic {
        FETCH  = 1'b0,
        LOADER = 1'b1
    } port_t;

    localparam int DEPTH_DEFAULT = 64;

    // True when a word address falls inside a memory of 'depth' words.
    function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
        return int'({16'd0, addr}) < depth;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, loader port and memory-side signals.
// The arbiter uses the slave view; the environment (requesters plus the
// memory itself) uses the master view.
interface imem_arbiter_if;

    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_err;

    logic        l_req;
    logic [15:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_ack;
    logic        l_err;

    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic [15:0] load_count;

    modport slave (
        input  f_req, f_addr, l_req, l_addr, l_wdata, mem_dataout,
        output f_ack, f_rdata, f_err, l_ack, l_err,
               mem_write, mem_addr, mem_datain, load_count
    );

    modport master (
        output f_req, f_addr, l_req, l_addr, l_wdata, mem_dataout,
        input  f_ack, f_rdata, f_err, l_ack, l_err,
               mem_write, mem_addr, mem_datain, load_count
    );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin selector: with both requests eligible the port that
// was not granted most recently wins; otherwise the lone requester wins.
// The output is a don't-care when neither request is eligible.
module rr_arb2
    import imem_arbiter_pkg::*;
(
    input  logic  req_fetch,
    input  logic  req_loader,
    input  port_t last_grant,
    output port_t winner
);

    // Pick the winner from the eligible requests and the last grant.
    always_comb begin
        winner = LOADER;
        if (req_fetch && req_loader) begin
            winner = (last_grant == LOADER) ? FETCH : LOADER;
        end else if (req_fetch) begin
            winner = FETCH;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing one single-port instruction memory between a fetch
// (read) port and a loader (write) port. Each grant lasts one cycle and
// is acknowledged in the following cycle; out-of-range accesses complete
// with the same timing but flag an error and never touch the memory.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus
);

    state_t      state_q, state_d;
    port_t       last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        f_ack_q, f_ack_d;
    logic        f_err_q, f_err_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic        l_ack_q, l_ack_d;
    logic        l_err_q, l_err_d;
    logic [15:0] load_count_q, load_count_d;

    logic        f_elig;
    logic        l_elig;
    logic        addr_ok;
    port_t       winner;

    // A port being served this cycle, or acked this cycle, still shows its
    // held request; it must not be considered again or it would be served
    // twice.
    assign f_elig  = bus.f_req && !f_ack_q && (state_q != G_FETCH);
    assign l_elig  = bus.l_req && !l_ack_q && (state_q != G_LOAD);
    assign addr_ok = addr_in_range(addr_q, DEPTH);

    rr_arb2 u_rr (
        .req_fetch  (f_elig),
        .req_loader (l_elig),
        .last_grant (last_q),
        .winner     (winner)
    );

    // Next-state logic: complete the current grant and arbitrate the next one.
    always_comb begin
        state_d      = IDLE;
        last_d       = last_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        f_ack_d      = 1'b0;
        l_ack_d      = 1'b0;
        f_err_d      = f_err_q;
        l_err_d      = l_err_q;
        f_rdata_d    = f_rdata_q;
        load_count_d = load_count_q;

        case (state_q)
            G_FETCH: begin
                f_ack_d   = 1'b1;
                f_err_d   = !addr_ok;
                f_rdata_d = addr_ok ? bus.mem_dataout : 32'd0;
            end
            G_LOAD: begin
                l_ack_d = 1'b1;
                l_err_d = !addr_ok;
            end
            default: ;
        endcase

        if (f_elig || l_elig) begin
            last_d = winner;
            if (winner == FETCH) begin
                state_d = G_FETCH;
                addr_d  = bus.f_addr;
            end else begin
                state_d = G_LOAD;
                addr_d  = bus.l_addr;
                wdata_d = bus.l_wdata;
                if (addr_in_range(bus.l_addr, DEPTH) && (load_count_q != 16'hFFFF)) begin
                    load_count_d = load_count_q + 16'd1;
                end
            end
        end
    end

    // State register; reset drops any grant in flight without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= LOADER;
            addr_q       <= '0;
            wdata_q      <= '0;
            f_ack_q      <= 1'b0;
            f_err_q      <= 1'b0;
            f_rdata_q    <= '0;
            l_ack_q      <= 1'b0;
            l_err_q      <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f_ack_q      <= f_ack_d;
            f_err_q      <= f_err_d;
            f_rdata_q    <= f_rdata_d;
            l_ack_q      <= l_ack_d;
            l_err_q      <= l_err_d;
            load_count_q <= load_count_d;
        end
    end

    // The write strobe is gated by reset directly so a reset landing in a
    // load grant cycle suppresses the write in that same cycle.
    assign bus.mem_write  = (state_q == G_LOAD) && addr_ok && !reset;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_datain = wdata_q;
    assign bus.f_ack      = f_ack_q;
    assign bus.f_err      = f_err_q;
    assign bus.f_rdata    = f_rdata_q;
    assign bus.l_ack      = l_ack_q;
    assign bus.l_err      = l_err_q;
    assign bus.load_count = load_count_q;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64, number of words in the instruction memory; addresses >= DEPTH are out of range.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 f_req  input  1  fetch-port read request; held with f_addr stable until f_ack.
REQ-005 f_addr  input  16  fetch word address.
REQ-006 f_ack  output  1  one-cycle pulse; read complete.
REQ-007 f_rdata  output  32  read data; valid while f_ack=1, held until the next fetch ack.
REQ-008 f_err  output  1  valid with f_ack; 1 = out-of-range address.
REQ-009 l_req  input  1  loader-port write request; held with l_addr/l_wdata stable until l_ack.
REQ-010 l_addr  input  16  loader word address.
REQ-011 l_wdata  input  32  loader write data.
REQ-012 l_ack  output  1  one-cycle pulse; write complete.
REQ-013 l_err  output  1  valid with l_ack; 1 = out-of-range, no write performed.
REQ-014 mem_write  output  1  memory write enable.
REQ-015 mem_addr  output  16  memory address.
REQ-016 mem_datain  output  32  memory write data.
REQ-017 mem_dataout  input  32  memory read data, combinational from mem_addr.
REQ-018 load_count  output  16  number of successful loader writes since reset, saturating at 16'hFFFF.

Function
REQ-019 The FSM SHALL have states IDLE, G_FETCH and G_LOAD; each grant lasts exactly one cycle.
REQ-020 In IDLE, G_FETCH or G_LOAD, the arbiter SHALL evaluate eligible requests each cycle; the next state is G_FETCH, G_LOAD or IDLE (none eligible).
REQ-021 A port's req SHALL be ineligible in the cycle its own ack is high, so a held req is not served twice.
REQ-022 Round-robin: with both ports eligible, the grant SHALL go to the port not granted most recently; with one eligible, that port SHALL be granted.
REQ-023 The grant edge SHALL latch the winner's address (and l_wdata) into internal registers; mem_addr/mem_datain SHALL drive the latched values during the grant cycle.
REQ-024 Latency: req first eligible in cycle N SHALL produce the grant cycle N+1 and the ack cycle N+2 (uncontended case).
REQ-025 G_FETCH: on its closing edge f_rdata SHALL load mem_dataout (0 if out of range) and f_ack SHALL pulse in the next cycle.
REQ-026 G_LOAD: mem_write = 1 only if in range and reset=0 (combinationally gated); l_ack SHALL pulse in the next cycle; load_count SHALL increment on the grant edge when in range.
REQ-027 Out-of-range accesses SHALL complete with the same latency, with err=1 and no memory write.
REQ-028 mem_write SHALL be 0 in IDLE and G_FETCH; mem_addr SHALL hold its last value in IDLE.
REQ-029 Fetch and loader acks SHALL never be asserted in the same cycle.

Reset
REQ-030 reset=1 SHALL force IDLE at the next edge, discard any in-flight grant without ack, and clear f_ack, l_ack, f_err, l_err, f_rdata, load_count and latched address/data to 0.
REQ-031 The last-grant register SHALL reset to LOADER, so the fetch port wins the first contention.
REQ-032 mem_write SHALL be 0 in every cycle where reset=1, including a reset that arrives during G_LOAD.

Structure
REQ-033 The state encoding, the port-identifier constants (FETCH, LOADER) and the DEPTH default SHALL live in the shared CPU package.
REQ-034 The round-robin selector SHALL be a sub-module rr_arb2 (inputs: two eligible requests and the last grant; output: the winner).

Verification
REQ-035 Loader writes 32'hDEADBEEF to addr 5 with no contention -> mem_write=1 in cycle N+1 only, l_ack in N+2, load_count=1.
REQ-036 Fetch addr 5 after REQ-035 -> f_ack in N+2 with f_rdata=32'hDEADBEEF and f_err=0.
REQ-037 f_req and l_req asserted in the same cycle after reset and held -> grant order FETCH, LOADER, FETCH, LOADER; acks alternate; never both acks in one cycle.
REQ-038 Loader write to addr 64 -> l_ack with l_err=1; mem_write stays 0; load_count unchanged.
REQ-039 Reset asserted during the G_LOAD cycle -> mem_write=0 in that cycle, no l_ack, and all outputs are 0 the following cycle.
